// File: rtl/picomips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : picomips_pkg
//  Description : Shared picoMIPS constants and types for the multiply engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package picomips_pkg;

    localparam int MUL_WIDTH = 8;

    // Decoder and multiply controller share this encoding for MULTI.
    localparam int               OPCODE_W  = 6;
    localparam logic [OPCODE_W-1:0] OPC_MULTI = 6'b000110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage
`default_nettype wire

// File: rtl/mul_shift_add_dp.sv
`default_nettype none
// ============================================================================
//  Module      : mul_shift_add_dp
//  Description : Right-shift shift-add multiplier datapath (accumulator,
//                multiplier shift register, adder). Signed operation when
//                MUL_SEQUENCER_SIGNED_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_shift_add_dp
    import picomips_pkg::*;
#(
    parameter int WIDTH     = MUL_WIDTH,
    parameter bit HIGH_HALF = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] half_next
);

`ifdef MUL_SEQUENCER_SIGNED_EN
    localparam logic c_SIGNED = 1'b1;
`else
    localparam logic c_SIGNED = 1'b0;
`endif

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mplr;
    logic [WIDTH:0]   w_acc_ext;
    logic [WIDTH:0]   w_mc_ext;
    logic [WIDTH:0]   w_sum;
    logic             w_sub;

    // Extra top bit holds the unsigned carry or the signed extension.
    assign w_acc_ext = {c_SIGNED & r_acc[WIDTH-1], r_acc};
    assign w_mc_ext  = {c_SIGNED & r_mcand[WIDTH-1], r_mcand};
    assign w_sub     = c_SIGNED & last;

    always_comb begin
        w_sum = w_acc_ext;
        if (r_mplr[0]) begin
            w_sum = w_sub ? (w_acc_ext - w_mc_ext) : (w_acc_ext + w_mc_ext);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_mplr  <= '0;
        end else if (load) begin
            r_mcand <= a;
            r_mplr  <= b;
            r_acc   <= '0;
        end else if (step) begin
            r_acc  <= w_sum[WIDTH:1];
            r_mplr <= {w_sum[0], r_mplr[WIDTH-1:1]};
        end
    end

    // Half of the product as it will stand after the current step.
    generate
        if (HIGH_HALF) begin : g_high
            assign half_next = w_sum[WIDTH:1];
        end else begin : g_low
            assign half_next = {w_sum[0], r_mplr[WIDTH-1:1]};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sequencer
//  Description : Multi-cycle MULTI engine: stalls the PC for WIDTH+1 cycles,
//                then pulses wr_en with the selected product half.
//                Define MUL_SEQUENCER_SIGNED_EN for two's complement operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_sequencer
    import picomips_pkg::*;
#(
    parameter int WIDTH     = MUL_WIDTH,
    parameter bit HIGH_HALF = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             wr_en,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int               c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

    mul_state_t       r_state;
    mul_state_t       w_next_state;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_half_next;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    assign w_last = (r_count == c_LAST);
    assign result = r_result;

    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        wr_en        = 1'b0;
        busy         = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                // Freeze the PC in the very cycle MULTI is decoded.
                stall = start;
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                stall  = 1'b1;
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                wr_en        = 1'b1;
                busy         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_count <= '0;
            end else if (w_step) begin
                r_count <= r_count + 1'b1;
            end
            if (w_step && w_last) begin
                r_result <= w_half_next;
            end
        end
    end

    mul_shift_add_dp #(
        .WIDTH     (WIDTH),
        .HIGH_HALF (HIGH_HALF)
    ) u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .step      (w_step),
        .last      (w_last),
        .a         (a),
        .b         (b),
        .half_next (w_half_next)
    );

endmodule
`default_nettype wire
